label_scanner: RTL and testbench

Walks a loaded program image in code memory after load, finds label definitions, and fills the label table through its write port (lbidw/typw/basew/countw/we). It is the writer end of the label table. The label table's read side is used by the execution unit. Code labels get type 0x86, with base/count spanning to the next label. Data labels get the type and length from the DATA header that directly follows the LB word.

---
 rtl/label_scanner.sv | 213 +++++++++++++++++++++
 tb/tb_label_scanner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/label_scanner.sv
// rtl/label_scanner.sv - walks a code image and writes label-table entries
// Optional LABELSCAN_DUPCHECK_EN: a repeated label id aborts the scan and sets dup_err.
module label_scanner #(
  parameter int         AW      = 16,
  parameter logic [7:0] LB_OP   = 8'h01,
  parameter logic [7:0] DATA_OP = 8'h2E
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [11:0]   lbidw,
  output logic [7:0]    typw,
  output logic [AW-1:0] basew,
  output logic [AW-1:0] countw,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic [12:0]   nlabels,
  output logic          dup_err
);
  localparam logic [7:0] CODE_TYP = 8'h86;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_FLUSH, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [11:0]   pend_lbid_q, pend_lbid_d;
  logic [AW-1:0] pend_base_q, pend_base_d;
  logic          pend_valid_q, pend_valid_d;
  logic          just_lb_q, just_lb_d;
  logic [11:0]   lbidw_q, lbidw_d;
  logic [7:0]    typw_q, typw_d;
  logic [AW-1:0] basew_q, basew_d;
  logic [AW-1:0] countw_q, countw_d;
  logic          we_q, we_d;
  logic [12:0]   nlabels_q, nlabels_d;
  logic          dup_err_q, dup_err_d;
  logic          busy_q, done_q;

  logic [7:0]  op;
  logic [11:0] lbid;
  logic [AW:0] dcount;
  logic        dup_hit;

  assign op     = mem_rdata[31:24];
  assign lbid   = mem_rdata[11:0];
  assign dcount = (AW+1)'(mem_rdata[15:0]);

`ifdef LABELSCAN_DUPCHECK_EN
  logic [4095:0] seen_q, seen_d;
  assign dup_hit = seen_q[lbid];
  always_ff @(posedge clk) seen_q <= seen_d;
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    end_d        = end_q;
    mem_addr_d   = mem_addr_q;
    pend_lbid_d  = pend_lbid_q;
    pend_base_d  = pend_base_q;
    pend_valid_d = pend_valid_q;
    just_lb_d    = just_lb_q;
    lbidw_d      = lbidw_q;
    typw_d       = typw_q;
    basew_d      = basew_q;
    countw_d     = countw_q;
    we_d         = 1'b0;
    nlabels_d    = nlabels_q;
    dup_err_d    = dup_err_q;
`ifdef LABELSCAN_DUPCHECK_EN
    seen_d       = seen_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FETCH;
          addr_d       = '0;
          end_d        = end_addr;
          mem_addr_d   = '0;
          pend_valid_d = 1'b0;
          just_lb_d    = 1'b0;
          nlabels_d    = '0;
          dup_err_d    = 1'b0;
`ifdef LABELSCAN_DUPCHECK_EN
          seen_d       = '0;
`endif
        end
      end
      S_FETCH: begin
        state_d = (addr_q >= {1'b0, end_q}) ? S_FLUSH : S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (op == LB_OP) begin
          if (dup_hit) begin
            dup_err_d    = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = S_DONE;
          end else begin
            // The previous label is code; it ends right where this label sits.
            if (pend_valid_q) begin
              we_d      = 1'b1;
              lbidw_d   = pend_lbid_q;
              typw_d    = CODE_TYP;
              basew_d   = pend_base_q;
              countw_d  = addr_q[AW-1:0] - pend_base_q;
              nlabels_d = nlabels_q + 13'd1;
            end
            pend_lbid_d  = lbid;
            pend_base_d  = addr_q[AW-1:0] + AW'(1);
            pend_valid_d = 1'b1;
            just_lb_d    = 1'b1;
            addr_d       = addr_q + (AW+1)'(1);
`ifdef LABELSCAN_DUPCHECK_EN
            seen_d[lbid] = 1'b1;
`endif
          end
        end else if (op == DATA_OP) begin
          if (just_lb_q) begin
            we_d         = 1'b1;
            lbidw_d      = pend_lbid_q;
            typw_d       = mem_rdata[23:16];
            basew_d      = addr_q[AW-1:0] + AW'(1);
            countw_d     = AW'(mem_rdata[15:0]);
            nlabels_d    = nlabels_q + 13'd1;
            pend_valid_d = 1'b0;
          end
          just_lb_d = 1'b0;
          addr_d    = addr_q + (AW+1)'(1) + dcount;
        end else begin
          just_lb_d = 1'b0;
          addr_d    = addr_q + (AW+1)'(1);
        end
        // Out-of-image addresses are never presented to code memory.
        if (state_d == S_FETCH && addr_d < {1'b0, end_q}) mem_addr_d = addr_d[AW-1:0];
      end
      S_FLUSH: begin
        if (pend_valid_q) begin
          we_d      = 1'b1;
          lbidw_d   = pend_lbid_q;
          typw_d    = CODE_TYP;
          basew_d   = pend_base_q;
          countw_d  = end_q - pend_base_q;
          nlabels_d = nlabels_q + 13'd1;
        end
        pend_valid_d = 1'b0;
        state_d      = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      end_q        <= '0;
      mem_addr_q   <= '0;
      pend_lbid_q  <= '0;
      pend_base_q  <= '0;
      pend_valid_q <= 1'b0;
      just_lb_q    <= 1'b0;
      lbidw_q      <= '0;
      typw_q       <= '0;
      basew_q      <= '0;
      countw_q     <= '0;
      we_q         <= 1'b0;
      nlabels_q    <= '0;
      dup_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      end_q        <= end_d;
      mem_addr_q   <= mem_addr_d;
      pend_lbid_q  <= pend_lbid_d;
      pend_base_q  <= pend_base_d;
      pend_valid_q <= pend_valid_d;
      just_lb_q    <= just_lb_d;
      lbidw_q      <= lbidw_d;
      typw_q       <= typw_d;
      basew_q      <= basew_d;
      countw_q     <= countw_d;
      we_q         <= we_d;
      nlabels_q    <= nlabels_d;
      dup_err_q    <= dup_err_d;
      busy_q       <= (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_FLUSH);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign mem_addr = mem_addr_q;
  assign lbidw    = lbidw_q;
  assign typw     = typw_q;
  assign basew    = basew_q;
  assign countw   = countw_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nlabels  = nlabels_q;
  assign dup_err  = dup_err_q;

endmodule

// File: tb/tb_label_scanner.sv
// tb/tb_label_scanner.sv - randomized self-checking bench for label_scanner
module tb_label_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, we, busy, done, dup_err;
  logic [15:0] end_addr, mem_addr, basew, countw;
  logic [31:0] mem_rdata;
  logic [11:0] lbidw;
  logic [7:0]  typw;
  logic [12:0] nlabels;

  label_scanner dut (
    .clk(clk), .reset(reset), .start(start), .end_addr(end_addr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lbidw(lbidw), .typw(typw), .basew(basew), .countw(countw),
    .we(we), .busy(busy), .done(done), .nlabels(nlabels), .dup_err(dup_err)
  );

  logic [31:0] mem [0:255];
  always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

  logic [51:0] got_q[$];
  logic [51:0] exp_q[$];
  int  done_cnt;
  bit  addr_seen [0:255];
  bit  payload [0:255];
  int  exp_visits;
  bit  exp_dup;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(negedge clk) begin
    if (we) got_q.push_back({lbidw, typw, basew, countw});
    if (done) done_cnt++;
    if (busy) addr_seen[mem_addr[7:0]] = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Labels are the LB words among the visited (non-payload) words. A label
  // directly followed by a DATA header takes that header's type and length;
  // otherwise it spans up to the next label or the end of the image.
  task automatic model(input int endp);
    int vis[$];
    int lbs[$];
    int a, ndone, p, nxt;
    logic [31:0] w;
    exp_q.delete();
    exp_dup = 1'b0;
    for (int i = 0; i < 256; i++) payload[i] = 1'b0;
    a = 0;
    while (a < endp) begin
      vis.push_back(a);
      w = mem[a];
      if (w[31:24] == 8'h2E) begin
        for (int q = a + 1; q <= a + int'(w[15:0]) && q < 256; q++) payload[q] = 1'b1;
        a = a + 1 + int'(w[15:0]);
      end else begin
        if (w[31:24] == 8'h01) lbs.push_back(vis.size() - 1);
        a++;
      end
    end
    exp_visits = vis.size();
    ndone = lbs.size();
`ifdef LABELSCAN_DUPCHECK_EN
    for (int k = 1; k < lbs.size() && !exp_dup; k++)
      for (int j = 0; j < k; j++)
        if (mem[vis[lbs[j]]][11:0] == mem[vis[lbs[k]]][11:0]) begin
          exp_dup = 1'b1;
          ndone = k;
        end
`endif
    for (int k = 0; k < ndone; k++) begin
      p = vis[lbs[k]];
      w = mem[p];
      if (lbs[k] + 1 < vis.size() && mem[p+1][31:24] == 8'h2E)
        exp_q.push_back({w[11:0], mem[p+1][23:16], 16'(p + 2), mem[p+1][15:0]});
      else if (!(exp_dup && k == ndone - 1)) begin
        nxt = (k + 1 < lbs.size()) ? vis[lbs[k+1]] : endp;
        exp_q.push_back({w[11:0], 8'h86, 16'(p + 1), 16'(nxt - p - 1)});
      end
    end
  endtask

  task automatic run_scan(input int endp, input bit poke);
    int k;
    int touched;
    bit timed_out;
    model(endp);
    got_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 256; i++) addr_seen[i] = 1'b0;
    if (exp_dup || exp_visits < 2) poke = 1'b0;
    end_addr = 16'(endp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      k++;
      start = (poke && k == 2);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("timeout", timed_out, 0);
    if (!exp_dup) check("latency", k, 2 * exp_visits + 2);
    check("nwrites", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("write", got_q[i], exp_q[i]);
    check("nlabels", nlabels, exp_q.size());
    check("dup_err", dup_err, exp_dup);
    check("done_cnt", done_cnt, 1);
    check("busy_after", busy, 0);
    touched = 0;
    for (int i = 0; i < 256; i++) if (payload[i] && addr_seen[i]) touched++;
    check("payload_rd", touched, 0);
  endtask

  task automatic load_basic();
    mem[0] = 32'h01000005; mem[1] = 32'h10000000; mem[2] = 32'h10000000;
    mem[3] = 32'h01000007; mem[4] = 32'h2E030002; mem[5] = 32'h000000AA;
    mem[6] = 32'h000000BB;
  endtask

  initial begin
    int n, cnt;
    bit seen_we;
    logic [31:0] w;
    reset = 1'b1;
    start = 1'b0;
    end_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_lbidw", lbidw, 0);
    check("rst_typw", typw, 0);
    check("rst_basew", basew, 0);
    check("rst_countw", countw, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nlabels", nlabels, 0);
    check("rst_dup_err", dup_err, 0);
    reset = 1'b0;
    @(negedge clk);

    load_basic();
    run_scan(7, 1'b0);

    mem[0] = 32'h01000001; mem[1] = 32'h01000002; mem[2] = 32'h10000000;
    run_scan(3, 1'b1);

    mem[0] = 32'h2E020003; mem[1] = 32'h10000000; mem[2] = 32'h10000000;
    mem[3] = 32'h10000000; mem[4] = 32'h01000009;
    run_scan(5, 1'b0);

    mem[0] = 32'h01000004; mem[1] = 32'h2E06FFFF;
    run_scan(2, 1'b0);

    mem[0] = 32'h01000003; mem[1] = 32'h01000003;
    run_scan(2, 1'b0);

    // Reset right after the first write of a scan, then a full rescan.
    load_basic();
    got_q.delete();
    end_addr = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_we = 1'b0;
    for (int c = 0; c < 200 && !seen_we; c++) begin
      @(negedge clk);
      seen_we = (got_q.size() > 0);
    end
    check("rst_mid_first_we", seen_we, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    done_cnt = 0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_we", got_q.size(), 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done_cnt, 0);
    run_scan(7, 1'b1);

    for (int iter = 0; iter < 30; iter++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: w = {8'h01, 12'($urandom), 12'($urandom_range(0, 15))};
          3, 4: begin
            cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 4);
            w = {8'h2E, 8'($urandom), 16'(cnt)};
          end
          default: begin
            w = $urandom;
            if (w[31:24] == 8'h01 || w[31:24] == 8'h2E) w[31:24] = 8'h55;
          end
        endcase
        mem[i] = w;
      end
      run_scan(n, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
